// File: rtl/perf_sched_pkg.sv
// Shared types, CSR address map and address helpers for the perf event
// scheduler and its accumulator bank.
package perf_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SAMPLE_LO,
        SAMPLE_HI,
        PROGRAM
    } sched_state_e;

    // Event code that leaves a physical counter idle.
    localparam logic [4:0]  EVT_NONE            = 5'd0;

    localparam logic [11:0] CSR_MHPM_EVENT_3    = 12'h323;
    localparam logic [11:0] CSR_MHPM_COUNTER_3  = 12'hB03;
    localparam logic [11:0] CSR_MHPM_COUNTER_3H = 12'hB83;

    function automatic logic [11:0] event_addr(input int unsigned p);
        return CSR_MHPM_EVENT_3 + p[11:0];
    endfunction

    function automatic logic [11:0] counter_addr(input int unsigned p);
        return CSR_MHPM_COUNTER_3 + p[11:0];
    endfunction

    function automatic logic [11:0] counterh_addr(input int unsigned p);
        return CSR_MHPM_COUNTER_3H + p[11:0];
    endfunction

    // True when addr selects one of the n event-select registers we own.
    function automatic logic is_event_csr(input logic [11:0] addr, input int unsigned n);
        int unsigned a;
        a = 32'(addr);
        return (a >= 32'(CSR_MHPM_EVENT_3)) && (a < 32'(CSR_MHPM_EVENT_3) + n);
    endfunction

endpackage

// File: rtl/perf_sched_acc_bank.sv
// 64-bit logical-event accumulators with clear and a combinational read port.
// Optional macro PERF_SCHED_SCALE_EN adds one active-cycle counter per group.
module perf_sched_acc_bank
    import perf_sched_pkg::*;
#(
    parameter int NumLogical = 12,
    parameter int NumPhys    = 6,
    parameter int NumGroups  = 2,
    parameter int IdxW       = 4,
    parameter int GW         = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            acc_en_i,
    input  logic [IdxW-1:0] acc_idx_i,
    input  logic [63:0]     sample_i,
    input  logic [IdxW-1:0] rd_idx_i,
    output logic [63:0]     rd_data_o
`ifdef PERF_SCHED_SCALE_EN
    ,
    input  logic            act_en_i,
    input  logic [GW-1:0]   act_grp_i,
    output logic [63:0]     act_o
`endif
);

    logic [63:0] acc_reg [NumLogical];

    for (genvar gi = 0; gi < NumLogical; gi++) begin : g_acc
        // Accumulate the sample into its slot; clear beats a same-cycle add.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                acc_reg[gi] <= '0;
            end else if (clear_i) begin
                acc_reg[gi] <= '0;
            end else if (acc_en_i && (acc_idx_i == IdxW'(gi))) begin
                acc_reg[gi] <= acc_reg[gi] + sample_i;
            end
        end
    end

    // Read mux; indices past the last logical event read as zero.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NumLogical; i++) begin
            if (32'(rd_idx_i) == 32'(i)) rd_data_o = acc_reg[i];
        end
    end

`ifdef PERF_SCHED_SCALE_EN
    logic [63:0] act_reg [NumGroups];

    for (genvar gi = 0; gi < NumGroups; gi++) begin : g_act
        // Count cycles during which this group owns the physical counters.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                act_reg[gi] <= '0;
            end else if (clear_i) begin
                act_reg[gi] <= '0;
            end else if (act_en_i && (act_grp_i == GW'(gi))) begin
                act_reg[gi] <= act_reg[gi] + 64'd1;
            end
        end
    end

    // Select the active-cycle counter of the group holding rd_idx_i.
    always_comb begin
        act_o = '0;
        for (int i = 0; i < NumGroups; i++) begin
            if ((32'(rd_idx_i) / 32'(NumPhys)) == 32'(i)) act_o = act_reg[i];
        end
    end
`endif

endmodule

// File: rtl/perf_event_scheduler.sv
// Time-multiplexes NumLogical events onto NumPhys hardware counters and
// shares the counter block's CSR port with the CSR file (CSR file first).
// Optional macro PERF_SCHED_SCALE_EN adds the act_o active-cycle output.
module perf_event_scheduler
    import perf_sched_pkg::*;
#(
    parameter int NumPhys    = 6,
    parameter int NumLogical = 12,
    parameter int Quantum    = 1024,
    parameter int XLEN       = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic                          cfg_we_i,
    input  logic [$clog2(NumLogical)-1:0] cfg_idx_i,
    input  logic [4:0]                    cfg_event_i,
    input  logic [$clog2(NumLogical)-1:0] acc_idx_i,
    output logic [63:0]                   acc_data_o,
    input  logic                          csr_req_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic                          csr_we_i,
    input  logic [XLEN-1:0]               csr_wdata_i,
    output logic [XLEN-1:0]               csr_rdata_o,
    output logic                          csr_ignored_o,
    output logic [11:0]                   pc_addr_o,
    output logic                          pc_we_o,
    output logic [XLEN-1:0]               pc_wdata_o,
    input  logic [XLEN-1:0]               pc_rdata_i,
`ifdef PERF_SCHED_SCALE_EN
    output logic [63:0]                   act_o,
`endif
    output logic                          busy_o
);

    localparam int NumGroups = (NumLogical + NumPhys - 1) / NumPhys;
    localparam int IdxW      = $clog2(NumLogical);
    localparam int PW        = (NumPhys > 1) ? $clog2(NumPhys) : 1;
    localparam int GW        = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam int TW        = $clog2(Quantum);
    localparam int SlotW     = $clog2(NumGroups * NumPhys + 1);
    localparam logic [SlotW-1:0] NumLogicalS = SlotW'(NumLogical);

    sched_state_e     state_reg, state_next;
    logic [PW-1:0]    p_reg, p_next;
    logic [GW-1:0]    g_reg, g_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [31:0]      lo_reg, lo_next;
    logic             en_reg, en_next;
    logic [4:0]       sel_reg [NumLogical];

    logic [GW-1:0]    g_adv;
    logic [SlotW-1:0] cur_slot, nxt_slot;
    logic             acc_en;
    logic [63:0]      acc_sample;
    logic [11:0]      fsm_addr;
    logic             fsm_we;
    logic [XLEN-1:0]  fsm_wdata;
    logic             csr_block;

    assign g_adv    = (g_reg == GW'(NumGroups - 1)) ? '0 : g_reg + GW'(1);
    assign cur_slot = SlotW'(g_reg) * SlotW'(NumPhys) + SlotW'(p_reg);
    assign nxt_slot = SlotW'(g_adv) * SlotW'(NumPhys) + SlotW'(p_reg);
    assign busy_o   = (state_reg != IDLE);

    for (genvar gi = 0; gi < NumLogical; gi++) begin : g_sel
        // Selector shadow registers; the live counter only sees them on INIT/PROGRAM.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sel_reg[gi] <= EVT_NONE;
            end else if (cfg_we_i && (cfg_idx_i == IdxW'(gi))) begin
                sel_reg[gi] <= cfg_event_i;
            end
        end
    end

    // FSM state, slot pointers, quantum timer and enable-edge history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            p_reg     <= '0;
            g_reg     <= '0;
            timer_reg <= '0;
            lo_reg    <= '0;
            en_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            g_reg     <= g_next;
            timer_reg <= timer_next;
            lo_reg    <= lo_next;
            en_reg    <= en_next;
        end
    end

    // Next-state logic; a CSR-file access freezes everything for that cycle.
    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        g_next     = g_reg;
        timer_next = timer_reg;
        lo_next    = lo_reg;
        en_next    = en_reg;
        acc_en     = 1'b0;
        acc_sample = 64'(pc_rdata_i);
        if (!csr_req_i) begin
            en_next = enable_i;
            unique case (state_reg)
                IDLE: begin
                    if (enable_i && !en_reg) begin
                        // Fresh start: load group 0 and restart the quantum.
                        state_next = INIT;
                        p_next     = '0;
                        g_next     = '0;
                        timer_next = '0;
                    end else if (enable_i) begin
                        if (timer_reg == TW'(Quantum - 1)) begin
                            state_next = SAMPLE_LO;
                            p_next     = '0;
                            timer_next = '0;
                        end else begin
                            timer_next = timer_reg + TW'(1);
                        end
                    end
                end
                INIT: begin
                    if (p_reg == PW'(NumPhys - 1)) begin
                        state_next = IDLE;
                        p_next     = '0;
                    end else begin
                        p_next = p_reg + PW'(1);
                    end
                end
                SAMPLE_LO: begin
                    lo_next = pc_rdata_i[31:0];
                    if (XLEN == 64) begin
                        acc_en     = (cur_slot < NumLogicalS);
                        state_next = PROGRAM;
                    end else begin
                        state_next = SAMPLE_HI;
                    end
                end
                SAMPLE_HI: begin
                    acc_sample = {pc_rdata_i[31:0], lo_reg};
                    acc_en     = (cur_slot < NumLogicalS);
                    state_next = PROGRAM;
                end
                PROGRAM: begin
                    if (p_reg == PW'(NumPhys - 1)) begin
                        state_next = IDLE;
                        p_next     = '0;
                        g_next     = g_adv;
                    end else begin
                        state_next = SAMPLE_LO;
                        p_next     = p_reg + PW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Port outputs: FSM access per state, overridden by the CSR file.
    always_comb begin
        fsm_addr  = '0;
        fsm_we    = 1'b0;
        fsm_wdata = '0;
        unique case (state_reg)
            INIT: begin
                fsm_addr  = event_addr(32'(p_reg));
                fsm_we    = 1'b1;
                fsm_wdata = XLEN'(sel_reg[IdxW'(p_reg)]);
            end
            SAMPLE_LO: fsm_addr = counter_addr(32'(p_reg));
            SAMPLE_HI: fsm_addr = counterh_addr(32'(p_reg));
            PROGRAM: begin
                fsm_addr  = event_addr(32'(p_reg));
                fsm_we    = 1'b1;
                fsm_wdata = (nxt_slot < NumLogicalS) ? XLEN'(sel_reg[IdxW'(nxt_slot)])
                                                     : XLEN'(EVT_NONE);
            end
            default: ;
        endcase

        // Event selects belong to the scheduler while it is running.
        csr_block = csr_we_i && is_event_csr(csr_addr_i, NumPhys) && (enable_i || busy_o);

        if (csr_req_i) begin
            pc_addr_o     = csr_addr_i;
            pc_we_o       = csr_we_i && !csr_block;
            pc_wdata_o    = csr_wdata_i;
            csr_rdata_o   = pc_rdata_i;
            csr_ignored_o = csr_block;
        end else begin
            pc_addr_o     = fsm_addr;
            pc_we_o       = fsm_we;
            pc_wdata_o    = fsm_wdata;
            csr_rdata_o   = '0;
            csr_ignored_o = 1'b0;
        end
    end

    perf_sched_acc_bank #(
        .NumLogical (NumLogical),
        .NumPhys    (NumPhys),
        .NumGroups  (NumGroups),
        .IdxW       (IdxW),
        .GW         (GW)
    ) u_acc_bank (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .acc_en_i  (acc_en),
        .acc_idx_i (IdxW'(cur_slot)),
        .sample_i  (acc_sample),
        .rd_idx_i  (acc_idx_i),
        .rd_data_o (acc_data_o)
`ifdef PERF_SCHED_SCALE_EN
        ,
        .act_en_i  (enable_i),
        .act_grp_i (g_reg),
        .act_o     (act_o)
`endif
    );

endmodule

// File: tb/tb_perf_event_scheduler.sv
// Scoreboard bench: counter-port writes are predicted into a queue and a
// monitor compares every write the DUT issues; accumulators and CSR mux
// behaviour are checked directly against hand-computed values.
`timescale 1ns/1ps
module tb_perf_event_scheduler;

    localparam int NP = 6;
    localparam int NL = 8;
    localparam int QT = 16;
    localparam int XL = 64;

    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0, clear = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_idx = '0, acc_idx = '0;
    logic [4:0]    cfg_event = '0;
    logic [63:0]   acc_data;
    logic          csr_req = 1'b0, csr_we = 1'b0;
    logic [11:0]   csr_addr = '0;
    logic [XL-1:0] csr_wdata = '0;
    logic [XL-1:0] csr_rdata;
    logic          csr_ignored;
    logic [11:0]   pc_addr;
    logic          pc_we;
    logic [XL-1:0] pc_wdata;
    logic [XL-1:0] pc_rdata;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [63:0]   cnt [NP];
    logic [63:0]   exp_acc [NL];
    logic [4:0]    sel_m [NL];

    always #5 clk = ~clk;

    perf_event_scheduler #(
        .NumPhys(NP), .NumLogical(NL), .Quantum(QT), .XLEN(XL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_event_i(cfg_event),
        .acc_idx_i(acc_idx), .acc_data_o(acc_data),
        .csr_req_i(csr_req), .csr_addr_i(csr_addr), .csr_we_i(csr_we),
        .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .csr_ignored_o(csr_ignored),
        .pc_addr_o(pc_addr), .pc_we_o(pc_we), .pc_wdata_o(pc_wdata),
        .pc_rdata_i(pc_rdata), .busy_o(busy)
    );

    // Counter-block stub: counters 3..8 return bench-set values.
    always_comb begin
        pc_rdata = '0;
        if (pc_addr >= 12'hB03 && pc_addr <= 12'hB08) pc_rdata = cnt[int'(pc_addr) - 'hB03];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [11:0] a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Predicted PROGRAM writes when the rotation loads group grp.
    task automatic push_prog(input int grp, input int p_lo, input int p_hi);
        for (int p = p_lo; p <= p_hi; p++) begin
            int l;
            l = grp * NP + p;
            push_w(12'h323 + 12'(p), (l < NL) ? 64'(sel_m[l]) : 64'd0);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (busy !== lvl && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (busy !== lvl) begin
            checks++; errors++;
            $display("FAIL %s: timeout, busy=%0b required %0b", name, busy, lvl);
        end
    endtask

    task automatic wait_sample(input logic [11:0] a, input string name);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!(busy && !pc_we && pc_addr == a) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!(busy && !pc_we && pc_addr == a)) begin
            checks++; errors++;
            $display("FAIL %s: timeout, pc_addr=%0h required %0h", name, pc_addr, a);
        end
    endtask

    task automatic chk_accs(input string tag);
        for (int i = 0; i < NL; i++) begin
            @(negedge clk);
            acc_idx = 3'(i);
            #1;
            chk($sformatf("%s_acc%0d", tag, i), acc_data, exp_acc[i]);
        end
    endtask

    // Monitor: every counter-port write must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk); #3;
            if (rst_n && pc_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h required no write", pc_addr, pc_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (pc_addr !== mon_e.addr || pc_wdata !== mon_e.data) begin
                        errors++;
                        $display("FAIL pc_write: got %0h/%0h required %0h/%0h",
                                 pc_addr, pc_wdata, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NP; i++) cnt[i] = '0;
        for (int i = 0; i < NL; i++) exp_acc[i] = '0;

        // Reset values.
        #3;
        chk("rst_pc_addr", 64'(pc_addr), 0);
        chk("rst_pc_we", 64'(pc_we), 0);
        chk("rst_pc_wdata", pc_wdata, 0);
        chk("rst_csr_rdata", csr_rdata, 0);
        chk("rst_csr_ignored", 64'(csr_ignored), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_acc", acc_data, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Selectors 0..7 = 1..8.
        for (int i = 0; i < NL; i++) begin
            @(negedge clk); #1;
            cfg_we = 1'b1; cfg_idx = 3'(i); cfg_event = 5'(i + 1);
            sel_m[i] = 5'(i + 1);
        end
        @(negedge clk); #1;
        cfg_we = 1'b0;

        // INIT loads selector[0..5] into event 3..8.
        for (int p = 0; p < NP; p++) push_w(12'h323 + 12'(p), 64'(p + 1));
        enable = 1'b1;
        wait_busy(1'b1, "init_start");
        wait_busy(1'b0, "init_end");

        // Rotation 1: group 0 sampled, group 1 programmed (p>=2 -> EVT_NONE).
        cnt[0] = 64'd100; cnt[1] = 64'd7; cnt[2] = 64'hFFFF_FFFF_FFFF_FFF6;
        cnt[3] = 64'd20;  cnt[4] = 64'd30; cnt[5] = 64'd50;
        push_prog(1, 0, NP - 1);
        wait_busy(1'b1, "rot1_start");
        wait_busy(1'b0, "rot1_end");
        for (int i = 0; i < NP; i++) exp_acc[i] = cnt[i];
        chk_accs("rot1");

        // New selector for index 0 shows up at the next PROGRAM of group 0.
        @(negedge clk); #1;
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_event = 5'd31;
        sel_m[0] = 5'd31;
        @(negedge clk); #1;
        cfg_we = 1'b0;

        // Rotation 2: group 1 sampled; slots 8..11 discarded.
        cnt[0] = 64'd40; cnt[1] = 64'd3;
        for (int i = 2; i < NP; i++) cnt[i] = 64'd99;
        push_prog(0, 0, NP - 1);
        wait_busy(1'b1, "rot2_start");
        wait_busy(1'b0, "rot2_end");
        exp_acc[6] = 64'd40; exp_acc[7] = 64'd3;
        chk_accs("rot2");

        // Rotation 3: CSR file steals the port for 3 cycles in SAMPLE_LO p=1.
        cnt[0] = 64'd1; cnt[1] = 64'd5; cnt[2] = 64'd15;
        cnt[3] = 64'd0; cnt[4] = 64'd2; cnt[5] = 64'd0;
        push_prog(1, 0, 0);
        wait_sample(12'hB04, "stall_reach");
        csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'h324; csr_wdata = 64'd9;
        #1;
        chk("ign_pc_we", 64'(pc_we), 0);
        chk("ign_pulse", 64'(csr_ignored), 1);
        chk("mux_addr", 64'(pc_addr), 64'h324);
        @(negedge clk); #1;
        csr_we = 1'b0; csr_addr = 12'hB04;
        #1;
        chk("csr_read", csr_rdata, 64'd5);
        chk("ign_once", 64'(csr_ignored), 0);
        @(negedge clk); #1;
        push_w(12'h340, 64'hABCD);
        push_prog(1, 1, NP - 1);
        csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 64'hABCD;
        #1;
        chk("other_write_pass", 64'(csr_ignored), 0);
        @(negedge clk); #1;
        csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        #1;
        chk("stall_hold_addr", 64'(pc_addr), 64'hB04);
        chk("stall_csr_rdata", csr_rdata, 0);
        wait_busy(1'b0, "rot3_end");
        exp_acc[0] = 64'd101; exp_acc[1] = 64'd12; exp_acc[2] = 64'd5;
        exp_acc[3] = 64'd20;  exp_acc[4] = 64'd32; exp_acc[5] = 64'd50;
        chk_accs("rot3");

        // Rotation 4: clear coincides with the slot-6 add; enable drops mid-rotation.
        cnt[0] = 64'd60; cnt[1] = 64'd4;
        for (int i = 2; i < NP; i++) cnt[i] = 64'd99;
        push_prog(0, 0, NP - 1);
        wait_sample(12'hB03, "clear_reach");
        clear = 1'b1;
        @(negedge clk); #1;
        clear = 1'b0; enable = 1'b0;
        wait_busy(1'b0, "rot4_end");
        for (int i = 0; i < NL; i++) exp_acc[i] = '0;
        exp_acc[7] = 64'd4;
        chk_accs("rot4");

        // Disabled: no further rotation.
        repeat (3 * QT) @(negedge clk);
        #1;
        chk("idle_after_disable", 64'(busy), 0);
        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
